gamepad_scanner: RTL and testbench

- Parametrised successor to the single-port controller reader: scans NUM_PORTS Genesis-style pads once per video frame.
- Drives each port's Select line through the 3-button or 6-button handshake and samples the six active-low pins per phase.
- Debounces across frames and reports per-button levels, rising-edge pulses, pad presence and pad type.
- Sits between the board pins and world; the scan is triggered by the falling edge of vga_vs.

---
 rtl/gamepad_scanner_if.sv | 23 ++
 rtl/gamepad_scanner.sv | 188 ++++++++++++++++++
 tb/tb_gamepad_scanner.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gamepad_scanner_if.sv
// Pad-side pin bundle for the gamepad scanner: six active-low inputs and one
// Select line per port, bit p belonging to port p.
interface gamepad_scanner_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0] pin1;
  logic [NUM_PORTS-1:0] pin2;
  logic [NUM_PORTS-1:0] pin3;
  logic [NUM_PORTS-1:0] pin4;
  logic [NUM_PORTS-1:0] pin6;
  logic [NUM_PORTS-1:0] pin9;
  logic [NUM_PORTS-1:0] select;

  modport master (
    input  pin1, pin2, pin3, pin4, pin6, pin9,
    output select
  );

  modport slave (
    output pin1, pin2, pin3, pin4, pin6, pin9,
    input  select
  );
endinterface

// File: rtl/gamepad_scanner.sv
// Frame-synchronous Genesis pad scanner: walks every port through the Select
// handshake once per vertical sync, then debounces and publishes the results.
module gamepad_scanner #(
  parameter int NUM_PORTS       = 2,
  parameter int SETTLE_CYCLES   = 500,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int SIX_BUTTON      = 1
) (
  input  logic                    clock_50,
  input  logic                    reset_key,
  input  logic                    vga_vs,
  gamepad_scanner_if.master       pad,
  input  logic                    clr_overrun,
  output logic [12*NUM_PORTS-1:0] buttons,
  output logic [12*NUM_PORTS-1:0] pressed,
  output logic [NUM_PORTS-1:0]    present,
  output logic [NUM_PORTS-1:0]    six_btn,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PHASES = (SIX_BUTTON != 0) ? 8 : 2;
  localparam int CYC_W  = $clog2(SETTLE_CYCLES);
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int NB     = 12 * NUM_PORTS;

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

  state_t               state, state_next;
  logic                 vs_meta, vs_sync, vs_prev, trig;
  logic [CYC_W-1:0]     cyc;
  logic [2:0]           phase;
  logic                 phase_end, last_phase;
  logic [NUM_PORTS-1:0] sel;
  logic [NB-1:0]        raw, eff, deb_next;
  logic [NUM_PORTS-1:0] raw_present, raw_six;
  logic [CNT_W-1:0]     cnt_q    [NB];
  logic [CNT_W-1:0]     cnt_next [NB];

  // Synchroniser resets low so a high vga_vs at reset release is not a fall.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= vga_vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign trig       = vs_prev & ~vs_sync;
  assign phase_end  = (state == SCAN) && (cyc == CYC_W'(SETTLE_CYCLES - 1));
  assign last_phase = (phase == 3'(PHASES - 1));

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) state <= IDLE;
    else            state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trig) state_next = SCAN;
      SCAN:    if (phase_end && last_phase) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel  = '1;
    busy = 1'b0;
    case (state)
      SCAN: begin
        sel  = {NUM_PORTS{~phase[0]}};
        busy = 1'b1;
      end
      UPDATE:  busy = 1'b1;
      default: ;
    endcase
  end

  assign pad.select = sel;

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      cyc   <= '0;
      phase <= '0;
    end else if (state != SCAN) begin
      cyc   <= '0;
      phase <= '0;
    end else if (phase_end) begin
      cyc   <= '0;
      phase <= phase + 3'd1;
    end else begin
      cyc <= cyc + CYC_W'(1);
    end
  end

  // Pins are captured only in the final settle cycle of each phase.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      raw         <= '0;
      raw_present <= '0;
      raw_six     <= '0;
    end else if (phase_end) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (phase)
          3'd0: begin
            raw[12*p+0] <= ~pad.pin1[p];
            raw[12*p+1] <= ~pad.pin2[p];
            raw[12*p+2] <= ~pad.pin3[p];
            raw[12*p+3] <= ~pad.pin4[p];
            raw[12*p+5] <= ~pad.pin6[p];
            raw[12*p+6] <= ~pad.pin9[p];
          end
          3'd1: begin
            raw[12*p+4]    <= ~pad.pin6[p];
            raw[12*p+7]    <= ~pad.pin9[p];
            raw_present[p] <= ~pad.pin3[p] & ~pad.pin4[p];
          end
          3'd5: raw_six[p] <= ~(pad.pin1[p] | pad.pin2[p] | pad.pin3[p] | pad.pin4[p]);
          3'd6: begin
            raw[12*p+10] <= ~pad.pin1[p];
            raw[12*p+9]  <= ~pad.pin2[p];
            raw[12*p+8]  <= ~pad.pin3[p];
            raw[12*p+11] <= ~pad.pin4[p];
          end
          default: ;
        endcase
      end
    end
  end

  // Absent pads clear at once; extended buttons count only on a detected 6-button pad.
  always_comb begin
    eff      = '0;
    deb_next = buttons;
    for (int i = 0; i < NB; i++) cnt_next[i] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < 12; b++) begin
        eff[12*p+b] = raw_present[p] && raw[12*p+b] &&
                      ((b < 8) || ((SIX_BUTTON != 0) && raw_six[p]));
        if (!raw_present[p]) begin
          deb_next[12*p+b] = 1'b0;
        end else if (eff[12*p+b] != buttons[12*p+b]) begin
          if (cnt_q[12*p+b] == CNT_W'(DEBOUNCE_FRAMES - 1)) deb_next[12*p+b] = eff[12*p+b];
          else cnt_next[12*p+b] = cnt_q[12*p+b] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the debounce counter array is reset too, so the first frames filter from a known count.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      buttons    <= '0;
      pressed    <= '0;
      present    <= '0;
      six_btn    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      frame_done <= (state == UPDATE);
      pressed    <= '0;
      if (state == UPDATE) begin
        buttons <= deb_next;
        pressed <= deb_next & ~buttons;
        present <= raw_present;
        six_btn <= raw_six & {NUM_PORTS{SIX_BUTTON != 0}};
        for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_next[i];
      end
    end
  end

  // A trigger landing while busy is dropped; it beats a simultaneous clear.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key)          overrun <= 1'b0;
    else if (trig && busy)   overrun <= 1'b1;
    else if (clr_overrun)    overrun <= 1'b0;
  end

endmodule

// File: tb/tb_gamepad_scanner.sv
// Randomised frame-level bench for gamepad_scanner: behavioural pads drive the
// pins and a frame-level debounce model predicts every published result.
module tb_gamepad_scanner;

  localparam int NP  = 2;
  localparam int S   = 4;
  localparam int DF  = 2;
  localparam int SIX = 1;
  localparam int P   = (SIX != 0) ? 8 : 2;
  localparam int LAT = P * S + 1;

  logic            clk, rst_n, vga_vs, clr_overrun;
  logic [12*NP-1:0] buttons, pressed;
  logic [NP-1:0]    present, six_btn;
  logic             frame_done, busy, overrun;

  gamepad_scanner_if #(.NUM_PORTS(NP)) pad_bus ();

  gamepad_scanner #(
    .NUM_PORTS(NP), .SETTLE_CYCLES(S), .DEBOUNCE_FRAMES(DF), .SIX_BUTTON(SIX)
  ) dut (
    .clock_50(clk), .reset_key(rst_n), .vga_vs(vga_vs), .pad(pad_bus),
    .clr_overrun(clr_overrun), .buttons(buttons), .pressed(pressed),
    .present(present), .six_btn(six_btn), .frame_done(frame_done),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Pad state: plugged, type, and buttons held for the whole frame.
  bit          plugged [NP];
  bit          is6     [NP];
  logic [11:0] held    [NP];

  // Frame-level reference state.
  logic [11:0]  deb [NP];
  int           cnt [NP][12];
  logic [12*NP-1:0] exp_buttons, exp_pressed;
  logic [NP-1:0]    exp_present, exp_six;
  bit               exp_overrun;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pins {pin9,pin6,pin4,pin3,pin2,pin1} a Genesis pad presents in a given phase.
  function automatic logic [5:0] pad_pins(input int p, input int ph);
    logic [11:0] b;
    b = held[p];
    if (!plugged[p]) return 6'h3F;
    if (ph == 6 && is6[p]) return ~{b[6], b[5], b[11], b[8], b[9], b[10]};
    if (ph == 5 && is6[p]) return ~{b[7], b[4], 4'b1111};
    if (ph % 2 == 0)       return ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    return ~{b[7], b[4], 1'b1, 1'b1, b[1], b[0]};
  endfunction

  // Valid data only in the last cycle of a decoded phase; noise everywhere else.
  task automatic drive_pins(input int k);
    logic [5:0] v;
    int ph;
    for (int p = 0; p < NP; p++) begin
      ph = k / S;
      if (k >= 0 && k < P * S && (k % S) == S - 1 && !(ph inside {2, 3, 4, 7}))
        v = pad_pins(p, ph);
      else
        v = 6'($urandom);
      pad_bus.pin1[p] = v[0];
      pad_bus.pin2[p] = v[1];
      pad_bus.pin3[p] = v[2];
      pad_bus.pin4[p] = v[3];
      pad_bus.pin6[p] = v[4];
      pad_bus.pin9[p] = v[5];
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      deb[p] = '0;
      for (int b = 0; b < 12; b++) cnt[p][b] = 0;
    end
    exp_buttons = '0;
    exp_pressed = '0;
    exp_present = '0;
    exp_six     = '0;
    exp_overrun = 1'b0;
  endtask

  task automatic model_frame();
    logic [11:0] eff, old;
    bit six;
    for (int p = 0; p < NP; p++) begin
      old = deb[p];
      six = plugged[p] && is6[p] && (SIX != 0);
      if (!plugged[p]) begin
        deb[p] = '0;
        for (int b = 0; b < 12; b++) cnt[p][b] = 0;
      end else begin
        eff = six ? held[p] : (held[p] & 12'h0FF);
        for (int b = 0; b < 12; b++) begin
          if (eff[b] != deb[p][b]) begin
            cnt[p][b]++;
            if (cnt[p][b] >= DF) begin
              deb[p][b] = eff[b];
              cnt[p][b] = 0;
            end
          end else begin
            cnt[p][b] = 0;
          end
        end
      end
      exp_buttons[12*p +: 12] = deb[p];
      exp_pressed[12*p +: 12] = deb[p] & ~old;
      exp_present[p]          = plugged[p];
      exp_six[p]              = six;
    end
  endtask

  function automatic logic [11:0] rand_buttons();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;   // a d-pad cannot press opposite directions
    if (b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  task automatic run_frame(input bit inject_vs);
    int k;
    int sel_bad;
    logic [NP-1:0] sel_exp;
    @(negedge clk);
    vga_vs = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_pins(-1);
      @(posedge clk); #1;
      if (i == 2) check("busy_early", busy, 1'b0);
      if (i == 3) check("busy_rise", busy, 1'b1);
    end
    k = 0;
    sel_bad = 0;
    while (!frame_done && k < 200) begin
      drive_pins(k);
      sel_exp = (k < P * S && ((k / S) % 2) == 1) ? '0 : '1;
      if (pad_bus.select !== sel_exp) sel_bad++;
      if (inject_vs && k == 4)  vga_vs = 1'b1;
      if (inject_vs && k == 10) vga_vs = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    if (inject_vs) exp_overrun = 1'b1;
    model_frame();
    check("latency", k, LAT);
    check("select_seq", sel_bad, 0);
    check("busy_done", busy, 1'b0);
    check("buttons", buttons, exp_buttons);
    check("pressed", pressed, exp_pressed);
    check("present", present, exp_present);
    check("six_btn", six_btn, exp_six);
    check("overrun", overrun, exp_overrun);
    check("select_idle", pad_bus.select, {NP{1'b1}});
    drive_pins(-1);
    @(posedge clk); #1;
    check("pressed_once", pressed, '0);
    check("frame_done_once", frame_done, 1'b0);
    vga_vs = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    vga_vs = 1'b1;
    clr_overrun = 1'b0;
    for (int p = 0; p < NP; p++) begin
      plugged[p] = 1'b0;
      is6[p]     = 1'b0;
      held[p]    = '0;
    end
    model_reset();
    drive_pins(-1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_select", pad_bus.select, {NP{1'b1}});
    check("rst_outputs", {buttons, pressed, present, six_btn}, '0);
    check("rst_flags", {frame_done, busy, overrun}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_select", pad_bus.select, {NP{1'b1}});
    check("idle_busy", busy, 1'b0);

    // No pads present.
    run_frame(1'b0);

    // Port 0: 3-button pad holding A for two frames.
    plugged[0] = 1'b1; is6[0] = 1'b0; held[0] = 12'h010;
    run_frame(1'b0);
    check("a_frame1", buttons[4], 1'b0);
    plugged[1] = 1'b1; is6[1] = 1'b1; held[1] = 12'hC00;
    run_frame(1'b0);
    check("six_port0", six_btn[0], 1'b0);
    run_frame(1'b0);
    check("z_mode_port1", {buttons[23], buttons[22], six_btn[1], present[1]}, 4'b1111);

    // Unplug port 0: cleared at once.
    plugged[0] = 1'b0;
    run_frame(1'b0);
    check("unplug_buttons", buttons[11:0], 12'h000);

    // Second vga_vs fall inside a scan.
    run_frame(1'b1);
    @(negedge clk); clr_overrun = 1'b1;
    @(negedge clk); clr_overrun = 1'b0;
    @(posedge clk); #1;
    exp_overrun = 1'b0;
    check("overrun_clr", overrun, 1'b0);

    // Randomised pad sequences with state held across several frames.
    for (int f = 0; f < 24; f++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          plugged[p] = ($urandom_range(0, 3) != 0);
          is6[p]     = 1'($urandom_range(0, 1));
          held[p]    = rand_buttons();
        end
      end
      run_frame(1'b0);
    end

    // Reset in the middle of a low Select phase.
    @(negedge clk);
    vga_vs = 1'b0;
    repeat (3) begin drive_pins(-1); @(posedge clk); #1; end
    for (int k = 0; k < S + 2; k++) begin drive_pins(k); @(posedge clk); #1; end
    check("pre_rst_select", pad_bus.select, {NP{1'b0}});
    rst_n = 1'b0;
    #1;
    check("midscan_select", pad_bus.select, {NP{1'b1}});
    check("midscan_busy", busy, 1'b0);
    check("midscan_buttons", buttons, '0);
    vga_vs = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    run_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
